// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline. Shadows the EX/MEM/WB
// destinations to drive EX operand forwarding, load-use stalls and ID-stage WB bypass.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W  = 4,
  parameter int NUM_SRC     = 2,
  parameter int ZERO_REG_EN = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]  id_src,
  input  logic [NUM_SRC-1:0]             id_src_used,
  input  logic [REG_ADDR_W-1:0]          id_rd,
  input  logic                           id_we,
  input  logic                           id_mem_read,
  input  logic                           flush,
  output logic                           stall,
  output logic [NUM_SRC*2-1:0]           fwd_sel,
  output logic [NUM_SRC-1:0]             id_wb_bypass,
  output logic [STALL_CNT_W-1:0]         stall_cycles
);

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  mem_read;
    logic [REG_ADDR_W-1:0] rd;
  } dst_t;

  typedef struct packed {
    dst_t                          dst;
    logic [NUM_SRC*REG_ADDR_W-1:0] src;
    logic [NUM_SRC-1:0]            src_used;
  } slot_t;

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = 1;

  // Only EX needs its sources; MEM and WB are consulted for their destination only.
  slot_t                  r_ex;
  dst_t                   r_mem;
  dst_t                   r_wb;
  slot_t                  w_id;
  logic [STALL_CNT_W-1:0] r_stall_cycles;
  logic                   w_ld_hit;
  logic                   w_unused_wb_ld;

  function automatic logic f_match(dst_t s, logic [REG_ADDR_W-1:0] reg_a);
    f_match = s.valid && s.we && (s.rd == reg_a) &&
              !((ZERO_REG_EN != 0) && (reg_a == '0));
  endfunction

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    w_ld_hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_src_used[k] && f_match(r_ex.dst, id_src[k*REG_ADDR_W +: REG_ADDR_W]))
        w_ld_hit = 1'b1;
    end
    stall = id_valid && !flush && r_ex.dst.mem_read && w_ld_hit;
  end

  always_comb begin
    fwd_sel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (r_ex.dst.valid && r_ex.src_used[k]) begin
        if (f_match(r_mem, r_ex.src[k*REG_ADDR_W +: REG_ADDR_W]) && !r_mem.mem_read)
          fwd_sel[2*k +: 2] = 2'b01;
        else if (f_match(r_wb, r_ex.src[k*REG_ADDR_W +: REG_ADDR_W]))
          fwd_sel[2*k +: 2] = 2'b10;
      end
    end
  end

  // The regfile has no write-through, so an ID read of the WB destination must bypass.
  always_comb begin
    id_wb_bypass = '0;
    for (int k = 0; k < NUM_SRC; k++)
      id_wb_bypass[k] = id_valid && id_src_used[k] &&
                        f_match(r_wb, id_src[k*REG_ADDR_W +: REG_ADDR_W]);
  end

  always_comb begin
    w_id              = '0;
    w_id.dst.valid    = id_valid && !stall && !flush;
    w_id.dst.we       = id_we;
    w_id.dst.mem_read = id_mem_read;
    w_id.dst.rd       = id_rd;
    w_id.src          = id_src;
    w_id.src_used     = id_src_used;
  end

  // NOTE: sequential state uses non-blocking assignments so WB<=MEM<=EX shift in one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: whole slots are cleared, not just valid, so no X ever reaches a compare.
      r_ex           <= '0;
      r_mem          <= '0;
      r_wb           <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex.dst;
      r_ex  <= w_id;
      if (stall && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + CNT_ONE;
    end
  end

  assign stall_cycles   = r_stall_cycles;
  assign w_unused_wb_ld = r_wb.mem_read;

endmodule
